// File: rtl/uart_ioport.sv
// uart_ioport: I/O-handshake responder moving 16-bit words over 8N1 UART, high byte first
// Ports:
//   clock, reset        system clock (rising edge), asynchronous active-low reset
//   io_read, io_write   load / store requests from the I/O controller (read wins if both)
//   wdata               word to transmit, captured when a write is accepted
//   rdata, ioack        received word and four-phase acknowledge
//   uart_rx, uart_tx    serial input (asynchronous) and output (idle high)
//   overrun, ferr       sticky receive-FIFO overflow and framing-error flags
module uart_ioport #(
  parameter int CLKS_PER_BIT = 16,
  parameter int RX_DEPTH     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ioack,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        overrun,
  output logic        ferr
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [15:0] BIT_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {C_IDLE, C_RD_HI, C_RD_LO, C_TX_HI, C_TX_LO, C_ACK} ctl_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_t;

  ctl_t        ctl_q, ctl_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, txword_q, txword_d, rdata_q, rdata_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic        ioack_q, ioack_d, uart_tx_q, uart_tx_d;
  rx_t         rx_q, rx_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        overrun_q, overrun_d, ferr_q, ferr_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [RX_DEPTH];
  logic [7:0]  mem_d [RX_DEPTH];
  logic        empty, full, push, pop, wr_ok;
  logic [7:0]  tx_byte;
  logic [9:0]  frame;

  assign empty   = wr_ptr_q == rd_ptr_q;
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop     = (ctl_q == C_RD_HI || ctl_q == C_RD_LO) && !empty;
  assign tx_byte = ctl_q == C_TX_HI ? txword_q[15:8] : txword_q[7:0];
  assign frame   = {1'b1, tx_byte, 1'b0};

  // Controller: uart_tx is registered, so each bit value is loaded one edge ahead of its slot.
  always_comb begin
    ctl_d     = ctl_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    txword_d  = txword_q;
    rdata_d   = rdata_q;
    ioack_d   = ioack_q;
    uart_tx_d = uart_tx_q;
    case (ctl_q)
      C_IDLE: begin
        if (io_read) ctl_d = C_RD_HI;
        else if (io_write) begin
          ctl_d     = C_TX_HI;
          txword_d  = wdata;
          uart_tx_d = 1'b0;
          tx_cnt_d  = BIT_M1;
          tx_bit_d  = '0;
        end
      end
      C_RD_HI: begin
        if (!empty) begin
          rdata_d[15:8] = mem_q[rd_ptr_q[AW-1:0]];
          ctl_d         = C_RD_LO;
        end
      end
      C_RD_LO: begin
        if (!empty) begin
          rdata_d[7:0] = mem_q[rd_ptr_q[AW-1:0]];
          ctl_d        = C_ACK;
          ioack_d      = 1'b1;
        end
      end
      C_TX_HI, C_TX_LO: begin
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - 16'd1;
        else begin
          tx_cnt_d = BIT_M1;
          if (tx_bit_q == 4'd9) begin
            // stop bit done: high byte chains straight into the low byte's start bit
            tx_bit_d  = '0;
            uart_tx_d = ctl_q == C_TX_LO;
            ioack_d   = ctl_q == C_TX_LO;
            ctl_d     = ctl_q == C_TX_HI ? C_TX_LO : C_ACK;
          end else begin
            tx_bit_d  = tx_bit_q + 4'd1;
            uart_tx_d = frame[tx_bit_q + 4'd1];
          end
        end
      end
      C_ACK: begin
        if (!io_read && !io_write) begin
          ctl_d   = C_IDLE;
          ioack_d = 1'b0;
        end
      end
      default: ctl_d = C_IDLE;
    endcase
  end

  // RX engine: samples at mid-bit, counted from the synchronized start edge.
  always_comb begin
    rx_d     = rx_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    ferr_d   = ferr_q;
    push     = 1'b0;
    case (rx_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_d     = R_START;
          rx_cnt_d = HALF_M1;
        end
      end
      R_START: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 16'd1;
        else begin
          rx_cnt_d = BIT_M1;
          rx_bit_d = '0;
          rx_d     = rx_s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 16'd1;
        else begin
          rx_cnt_d = BIT_M1;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_d = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 16'd1;
        else begin
          push   = rx_s2_q;
          ferr_d = ferr_q | !rx_s2_q;
          rx_d   = rx_s2_q ? R_IDLE : R_WAIT;
        end
      end
      R_WAIT: if (rx_s2_q) rx_d = R_IDLE;
      default: rx_d = R_IDLE;
    endcase
  end

  // FIFO: a pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    wr_ok = push && (!full || pop);
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_ptr_q[AW-1:0]] = rx_sh_q;
    wr_ptr_d  = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overrun_d = overrun_q | (push && full && !pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctl_q     <= C_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      txword_q  <= '0;
      rdata_q   <= '0;
      ioack_q   <= 1'b0;
      uart_tx_q <= 1'b1;
      rx_q      <= R_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_q     <= '{default: '0};
    end else begin
      ctl_q     <= ctl_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      txword_q  <= txword_d;
      rdata_q   <= rdata_d;
      ioack_q   <= ioack_d;
      uart_tx_q <= uart_tx_d;
      rx_q      <= rx_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
    end
  end

  assign rdata   = rdata_q;
  assign ioack   = ioack_q;
  assign uart_tx = uart_tx_q;
  assign overrun = overrun_q;
  assign ferr    = ferr_q;
endmodule

// File: tb/tb_uart_ioport.sv
// tb_uart_ioport: scoreboard bench for uart_ioport with a queue-based FIFO/UART reference model
module tb_uart_ioport;
  localparam int CPB = 4;

  logic        clock, reset, io_read, io_write, uart_rx;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ioack, uart_tx, overrun, ferr;

  uart_ioport #(.CLKS_PER_BIT(CPB), .RX_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .io_read(io_read), .io_write(io_write), .wdata(wdata),
    .rdata(rdata), .ioack(ioack), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .overrun(overrun), .ferr(ferr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {bit rd; logic [15:0] data; int cyc;} exp_t;
  exp_t       sb[$];
  logic [7:0] exp_tx[$];
  logic [7:0] model_q[$];
  bit         model_ovr = 0, model_ferr = 0;
  int         n_cmp = 0, n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  // Acknowledge monitor: each rising ioack consumes one expected response.
  initial begin
    bit   prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clock);
      if (!reset) prev = 0;
      else begin
        if (ioack && !prev) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ack: got ioack=1, expected none (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            if (e.rd) chk("ack_rdata", 32'(rdata), 32'(e.data));
            if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
          end
        end
        prev = ioack;
      end
    end
  end

  // TX monitor: samples every cycle of a frame, so bit length and framing are checked exactly.
  initial begin
    logic [9:0] bits;
    logic [7:0] eb;
    bit         ok, aborted;
    forever begin
      @(negedge clock);
      if (reset && uart_tx === 1'b0) begin
        ok = 1;
        aborted = 0;
        bits = '0;
        for (int i = 0; i < 10 * CPB; i++) begin
          if (i > 0) @(negedge clock);
          if (!reset) begin
            aborted = 1;
            break;
          end
          if (i % CPB == 0) bits[i / CPB] = uart_tx;
          else if (uart_tx !== bits[i / CPB]) ok = 0;
        end
        if (!aborted) begin
          chk("tx_frame_shape", 32'({ok, bits[9], bits[0]}), 32'd6);
          if (exp_tx.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_unexpected_frame: got byte %02h, expected no frame", bits[8:1]);
          end else begin
            eb = exp_tx.pop_front();
            chk("tx_byte", 32'(bits[8:1]), 32'(eb));
          end
        end
      end
    end
  end

  task automatic send_byte(logic [7:0] b, bit stop, bit model);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      tick(CPB);
    end
    uart_rx = 1'b1;
    tick(4);
    if (model) begin
      if (!stop) model_ferr = 1;
      else if (model_q.size() < 4) model_q.push_back(b);
      else model_ovr = 1;
    end
  endtask

  task automatic issue(bit rd, bit wr, logic [15:0] w, logic [15:0] d, int delta);
    exp_t e;
    io_read = rd;
    io_write = wr;
    wdata = w;
    e.rd = rd;
    e.data = d;
    e.cyc = delta < 0 ? -1 : cyc + delta;
    sb.push_back(e);
    if (!rd && wr) begin
      exp_tx.push_back(w[15:8]);
      exp_tx.push_back(w[7:0]);
    end
  endtask

  task automatic finish_req(string name, logic [15:0] d, bit rd);
    int n;
    n = 0;
    while (!ioack && n < 2000) begin
      tick(1);
      n++;
    end
    if (!ioack) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no ioack, expected ioack within 2000 cycles", name);
    end
    io_read = 1'b0;
    io_write = 1'b0;
    tick(1);
    chk({name, "_ack_fall"}, 32'(ioack), 32'd0);
    if (rd) begin
      tick(4);
      chk({name, "_rdata_hold"}, 32'(rdata), 32'(d));
    end
    tick(1);
  endtask

  task automatic do_write(string name, logic [15:0] w);
    issue(1'b0, 1'b1, w, 16'h0, 1 + 20 * CPB);
    tick(1);
    chk({name, "_start_bit"}, 32'(uart_tx), 32'd0);
    wdata = 16'($urandom);
    finish_req(name, 16'h0, 1'b0);
  endtask

  task automatic do_read(string name, bit both);
    logic [7:0] h, l;
    logic [15:0] d;
    int hi_cnt;
    h = model_q.pop_front();
    l = model_q.pop_front();
    d = {h, l};
    issue(1'b1, both, 16'($urandom), d, 3);
    if (both) begin
      hi_cnt = 0;
      for (int i = 0; i < 30; i++) begin
        tick(1);
        if (uart_tx === 1'b1) hi_cnt++;
      end
      chk({name, "_tx_idle"}, hi_cnt, 30);
    end
    finish_req(name, d, 1'b1);
  endtask

  initial begin
    logic [15:0] w;
    int          hi_cnt;
    io_read = 1'b0;
    io_write = 1'b0;
    wdata = '0;
    uart_rx = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
    tick(3);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_ioack", 32'(ioack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    reset = 1'b1;
    tick(3);

    do_write("wr_1234", 16'h1234);
    for (int i = 0; i < 2; i++) do_write("wr_rand", 16'($urandom));

    send_byte(8'hAB, 1'b1, 1'b1);
    send_byte(8'hCD, 1'b1, 1'b1);
    do_read("rd_abcd", 1'b0);

    issue(1'b1, 1'b0, 16'h0, 16'h007F, -1);
    tick(20);
    chk("rd_empty_wait", 32'(ioack), 32'd0);
    send_byte(8'h00, 1'b1, 1'b0);
    chk("rd_half_wait", 32'(ioack), 32'd0);
    send_byte(8'h7F, 1'b1, 1'b0);
    finish_req("rd_before_data", 16'h007F, 1'b1);

    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom), 1'b1, 1'b1);
      send_byte(8'($urandom), 1'b1, 1'b1);
      do_read("rd_rand", 1'b0);
    end

    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b1);
    chk("overrun_set", 32'(overrun), 32'(model_ovr));
    do_read("rd_ovr_a", 1'b0);
    do_read("rd_ovr_b", 1'b0);
    chk("overrun_sticky", 32'(overrun), 32'(model_ovr));

    send_byte(8'h55, 1'b0, 1'b1);
    chk("ferr_set", 32'(ferr), 32'(model_ferr));
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(20);
    chk("glitch_ferr", 32'(ferr), 32'(model_ferr));
    chk("glitch_overrun", 32'(overrun), 32'(model_ovr));
    send_byte(8'($urandom), 1'b1, 1'b1);
    send_byte(8'($urandom), 1'b1, 1'b1);
    do_read("rd_after_err", 1'b0);

    send_byte(8'($urandom), 1'b1, 1'b1);
    send_byte(8'($urandom), 1'b1, 1'b1);
    do_read("rd_and_wr", 1'b1);

    send_byte(8'hEE, 1'b1, 1'b0);
    io_write = 1'b1;
    wdata = 16'h00FF;
    tick(10);
    chk("mid_write_low", 32'(uart_tx), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("reset_uart_tx", 32'(uart_tx), 32'd1);
    chk("reset_ioack", 32'(ioack), 32'd0);
    io_write = 1'b0;
    tick(3);
    reset = 1'b1;
    model_q.delete();
    model_ovr = 0;
    model_ferr = 0;
    tick(2);
    chk("post_reset_overrun", 32'(overrun), 32'(model_ovr));
    chk("post_reset_ferr", 32'(ferr), 32'(model_ferr));
    issue(1'b1, 1'b0, 16'h0, 16'h5AA5, -1);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ioack === 1'b0) hi_cnt++;
    end
    chk("post_reset_fifo_empty", hi_cnt, 20);
    send_byte(8'h5A, 1'b1, 1'b0);
    send_byte(8'hA5, 1'b1, 1'b0);
    finish_req("rd_post_reset", 16'h5AA5, 1'b1);

    w = 16'($urandom);
    do_write("wr_final", w);
    tick(5);
    chk("sb_drained", sb.size(), 0);
    chk("tx_drained", exp_tx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_ioport.md
# uart_ioport

Peripheral-side responder for the CPU's syscall I/O handshake. It turns single-word `io_read` and `io_write` requests into UART traffic: each 16-bit word is carried as two 8N1 bytes, high byte first. It sits directly downstream of the I/O controller: it consumes `io_read`, `io_write` and the accumulator value, and it returns `ioack` and the read data that the accumulator latches.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range 4..65535.
- `RX_DEPTH`, 4: receive byte FIFO depth; must be a power of two, at least 2.

Ports:
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `io_read`  in  1  load request: return one word.
- `io_write`  in  1  store request: send `wdata`.
- `wdata`  in  16  word to send; sampled in the cycle the write is accepted.
- `rdata`  out  16  received word; valid while `ioack` is high after a read.
- `ioack`  out  1  four-phase acknowledge.
- `uart_rx`  in  1  serial input; asynchronous to `clock`.
- `uart_tx`  out  1  serial output; idle level is 1.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `ferr`  out  1  sticky: a stop bit was sampled as 0.

## Operation
- Reset values: `uart_tx`=1, `ioack`=0, `rdata`=0, `overrun`=0, `ferr`=0. The FIFO is empty, the controller is in IDLE and the RX engine is idle.
- Controller state machine: IDLE, RD_HI, RD_LO, TX_HI, TX_LO, ACK.
- IDLE:
  - If `io_read`=1, go to RD_HI. Read has priority when both requests are high; the write is then ignored.
  - Otherwise, if `io_write`=1, capture `wdata` into `txword` and go to TX_HI.
- RD_HI: when the FIFO is non-empty, pop one byte into `rdata[15:8]` and go to RD_LO. The controller waits indefinitely on an empty FIFO.
- RD_LO: when the FIFO is non-empty, pop one byte into `rdata[7:0]` and go to ACK.
- TX_HI: send `txword[15:8]` as one frame, then go to TX_LO.
- TX_LO: send `txword[7:0]` as one frame, then go to ACK.
- Frame format: start bit 0, eight data bits LSB first, stop bit 1. Each bit lasts exactly `CLKS_PER_BIT` cycles. Frames are back-to-back, with no idle gap between the high and low byte.
- ACK:
  - `ioack`=1.
  - When `io_read`=0 and `io_write`=0, go to IDLE; `ioack` is 0 in IDLE.
  - Requests are never re-sampled in ACK.
- `rdata` holds its value outside RD_HI/RD_LO. It changes only on a pop.
- RX engine, running independently of the controller:
  - Two-flop synchronizer on `uart_rx`.
  - Start detection: a 1→0 transition of the synchronized line while the engine is idle.
  - Start check: wait `CLKS_PER_BIT/2` cycles (integer division). If the line is 1, abort as a glitch with no flags set; otherwise continue.
  - Data and stop: sample 8 data bits and then the stop bit, one sample every `CLKS_PER_BIT` cycles.
  - Stop bit 1: push the byte into the FIFO. If the FIFO is full, drop the byte and set `overrun`.
  - Stop bit 0: discard the byte and set `ferr`. The engine then waits for the line to return to 1 before re-arming.
- FIFO:
  - Circular buffer with pointers one bit wider than the address, so full and empty are distinguished.
  - A push and a pop in the same cycle are both performed. When the FIFO is full, the simultaneous pop frees the slot first, so the byte is not dropped.
- Sticky flags clear only on reset.

## Timing
- A write accepted in cycle N drives the start bit of the high byte on `uart_tx` from cycle N+1.
- `ioack` rises in cycle N+1+20·`CLKS_PER_BIT`, the first cycle after the low byte's stop bit.
- Read with at least 2 bytes queued when accepted in cycle N: pops occur in cycles N+1 and N+2, and `ioack`=1 from cycle N+3.
- Read with an empty FIFO: each pop happens in the cycle after the corresponding push.
- `ioack` falls one cycle after both requests are observed low.
- A new request is accepted no earlier than the cycle after `ioack` falls.
- Receive latency: a byte reaches the FIFO about `CLKS_PER_BIT`·9.5 + 3 cycles after its start edge on the pin. The extra cycles cover synchronizer plus detect.
- Reset mid-frame: `uart_tx` returns to 1 asynchronously. Partial RX and TX bytes are lost, and the FIFO is emptied.

## Test plan
- Write: `CLKS_PER_BIT`=4, write 0x1234.
  - Required: `uart_tx` shows frames 0x12 then 0x34, each bit 4 cycles.
  - Required: `ioack` high at cycle N+81, then low one cycle after `io_write` drops.
- Queued read: inject serial bytes 0xAB and 0xCD, then issue a read.
  - Required: `rdata`=0xABCD with `ioack`=1 three cycles after the request.
  - Required: `rdata` is held after the handshake completes.
- Read before data: issue a read with the FIFO empty.
  - Required: `ioack` stays 0.
  - Then inject 0x00 and 0x7F: required `ioack`=1 and `rdata`=0x007F.
- Overrun: inject 5 bytes 0x01..0x05 with no read.
  - Required: `overrun`=1.
  - Two reads then return 0x0102 and 0x0304.
- Framing error and glitch:
  - A frame with stop bit 0 sets `ferr`=1 and pushes nothing.
  - A low pulse of 1 cycle on `uart_rx` pushes nothing and sets no flag.
- Concurrency and reset:
  - `io_read` and `io_write` high together: a read is performed and `uart_tx` stays 1.
  - Reset asserted mid-write: `uart_tx`=1 and `ioack`=0 immediately, and the FIFO is empty.
